// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response and data-memory bus bundle for the stack sequencer
interface stack_ctrl_if;
  logic        push_req;
  logic        pop_req;
  logic        sp_load;
  logic [31:0] push_data;
  logic [31:0] sp_load_val;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] pop_data;
  logic [31:0] sp;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport slave (
    input  push_req, pop_req, sp_load, push_data, sp_load_val, mem_rdata, mem_ack,
    output busy, done, err, pop_data, sp, mem_en, mem_rw, mem_addr, mem_wdata
  );
  modport master (
    output push_req, pop_req, sp_load, push_data, sp_load_val, mem_rdata, mem_ack,
    input  busy, done, err, pop_data, sp, mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: hardware stack sequencer owning SP and the single-word memory transaction
module stack_ctrl #(
  parameter logic [31:0] STACK_BASE  = 32'h0000_0000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0400
) (
  input logic        clk,
  input logic        reset,
  stack_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;
  localparam logic [31:0] SPAN = STACK_LIMIT - STACK_BASE;
  state_t state;
  logic   load_bad;
  // offset from base wraps to a huge value below base, so one compare covers both bounds
  assign load_bad = (bus.sp_load_val[1:0] != 2'b00) || ((bus.sp_load_val - STACK_BASE) > SPAN);
  // request arbitration, memory handshake and one-cycle completion pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.sp        <= STACK_BASE;
      bus.pop_data  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_rw    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sp_load) begin
            bus.busy <= 1'b1;
            if (load_bad) begin
              state   <= ERR;
              bus.err <= 1'b1;
            end else begin
              state    <= DONE;
              bus.sp   <= bus.sp_load_val;
              bus.done <= 1'b1;
            end
          end else if (bus.push_req) begin
            bus.busy <= 1'b1;
            if (bus.sp == STACK_LIMIT) begin
              state   <= ERR;
              bus.err <= 1'b1;
            end else begin
              state         <= XFER;
              bus.mem_en    <= 1'b1;
              bus.mem_rw    <= 1'b1;
              bus.mem_addr  <= bus.sp;
              bus.mem_wdata <= bus.push_data;
            end
          end else if (bus.pop_req) begin
            bus.busy <= 1'b1;
            if (bus.sp == STACK_BASE) begin
              state   <= ERR;
              bus.err <= 1'b1;
            end else begin
              state        <= XFER;
              bus.mem_en   <= 1'b1;
              bus.mem_rw   <= 1'b0;
              bus.mem_addr <= bus.sp - 32'd4;
            end
          end
        end
        XFER: begin
          if (bus.mem_ack) begin
            state      <= DONE;
            bus.mem_en <= 1'b0;
            bus.done   <= 1'b1;
            bus.sp     <= bus.mem_rw ? bus.sp + 32'd4 : bus.sp - 32'd4;
            if (!bus.mem_rw) bus.pop_data <= bus.mem_rdata;
          end
        end
        DONE, ERR: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
